// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character path.
// Holds the character width, the "no key" code and the default queue depth.
package kbd_pkg;

    localparam int unsigned KBD_DATA_W     = 8;
    localparam int unsigned KBD_FIFO_DEPTH = 16;
    localparam int unsigned KBD_DROP_W     = 8;

    localparam logic [KBD_DATA_W-1:0] KBD_NOKEY    = KBD_DATA_W'(0);
    localparam logic [KBD_DROP_W-1:0] KBD_DROP_MAX = KBD_DROP_W'(255);

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [KBD_DROP_W-1:0] kbd_sat_inc(input logic [KBD_DROP_W-1:0] v);
        return (v == KBD_DROP_MAX) ? v : v + KBD_DROP_W'(1);
    endfunction

endpackage

// File: rtl/kbd_char_fifo_if.sv
// Bus between the decoder/CPU side (master) and the character queue (slave).
// Carries the key code, pop handshake, popped data and queue status.
interface kbd_char_fifo_if
    import kbd_pkg::*;
#(
    parameter int unsigned DATA_W = KBD_DATA_W,
    parameter int unsigned DEPTH  = KBD_FIFO_DEPTH
);

    logic                      flush;
    logic [DATA_W-1:0]         in_code;
    logic                      rden;
    logic [DATA_W-1:0]         dataout;
    logic                      dout_valid;
    logic                      empty;
    logic                      full;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic [KBD_DROP_W-1:0]     drop_cnt;

    modport master (
        output flush, in_code, rden,
        input  dataout, dout_valid, empty, full, count, overflow, drop_cnt
    );

    modport slave (
        input  flush, in_code, rden,
        output dataout, dout_valid, empty, full, count, overflow, drop_cnt
    );

endinterface

// File: rtl/kbd_fifo_mem.sv
// Character storage: synchronous write port, asynchronous read port.
// No reset; the owner gates the read data with its own occupancy state.
module kbd_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kbd_char_fifo.sv
// Key-event queue between the scan-code decoder and the CPU keyboard port.
// Turns a level-held code into one entry per key press; FWFT selects the read style.
module kbd_char_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DATA_W = KBD_DATA_W,
    parameter int unsigned DEPTH  = KBD_FIFO_DEPTH,
    parameter int unsigned FWFT   = 0
) (
    input  logic           clk,
    input  logic           rst,
    kbd_char_fifo_if.slave bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] NOKEY     = DATA_W'(KBD_NOKEY);

    logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [KBD_DROP_W-1:0] drop_q, drop_d;
    logic [DATA_W-1:0]     last_q, last_d;
    logic                  arm_q, arm_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  dv_q, dv_d;

    logic [DATA_W-1:0]     rdata_c;
    logic                  empty_c, full_c, key_ev_c, pop_c, push_c, drop_c;

    kbd_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_c),
        .waddr_i (tail_q),
        .wdata_i (bus.in_code),
        .raddr_i (head_q),
        .rdata_o (rdata_c)
    );

    // Status comes from count only, so every slot is usable.
    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == DEPTH_CNT);
    assign key_ev_c = (bus.in_code != NOKEY) && (arm_q || (bus.in_code != last_q));
    assign pop_c    = !bus.flush && bus.rden && !empty_c;
    assign push_c   = !bus.flush && key_ev_c && (!full_c || pop_c);
    assign drop_c   = !bus.flush && key_ev_c && full_c && !pop_c;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        last_d     = bus.in_code;
        arm_d      = arm_q;
        dout_d     = '0;
        dv_d       = 1'b0;

        if (bus.in_code == NOKEY) arm_d = 1'b1;
        else if (key_ev_c)        arm_d = 1'b0;

        if (bus.flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (push_c) tail_d = tail_q + AW'(1);
            if (pop_c) begin
                head_d = head_q + AW'(1);
                dout_d = rdata_c;
                dv_d   = 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop_c) begin
                overflow_d = 1'b1;
                drop_d     = kbd_sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            last_q     <= '0;
            arm_q      <= 1'b1;
            dout_q     <= '0;
            dv_q       <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            last_q     <= last_d;
            arm_q      <= arm_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
        end
    end

    // Fall-through mode presents the head entry straight from storage.
    assign bus.dataout    = (FWFT != 0) ? (empty_c ? {DATA_W{1'b0}} : rdata_c) : dout_q;
    assign bus.dout_valid = (FWFT != 0) ? !empty_c : dv_q;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Bench for kbd_char_fifo: three configurations share one stimulus stream and are
// compared every cycle against a queue-based model of the key-event rules.
module tb_kbd_char_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_code;
    logic       rden;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    kbd_char_fifo_if #(.DATA_W(8), .DEPTH(4))  if_a ();
    kbd_char_fifo_if #(.DATA_W(8), .DEPTH(4))  if_b ();
    kbd_char_fifo_if #(.DATA_W(8), .DEPTH(16)) if_c ();

    assign if_a.flush = flush;  assign if_a.in_code = in_code;  assign if_a.rden = rden;
    assign if_b.flush = flush;  assign if_b.in_code = in_code;  assign if_b.rden = rden;
    assign if_c.flush = flush;  assign if_c.in_code = in_code;  assign if_c.rden = rden;

    kbd_char_fifo #(.DATA_W(8), .DEPTH(4),  .FWFT(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    kbd_char_fifo #(.DATA_W(8), .DEPTH(4),  .FWFT(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    kbd_char_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // Reference state: contents as queues, plus status and registered read data.
    logic [7:0] q4[$];
    logic [7:0] q16[$];
    logic       ovf4, ovf16, dv4, dv16;
    logic [7:0] drop4, drop16, dout4, dout16;
    logic [7:0] prev_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q4.delete();  q16.delete();
        ovf4 = 1'b0;  ovf16 = 1'b0;  dv4 = 1'b0;  dv16 = 1'b0;
        drop4 = 8'd0; drop16 = 8'd0; dout4 = 8'd0; dout16 = 8'd0;
        prev_code = 8'd0;
    endtask

    task automatic step_model(input bit big, input bit ev);
        logic [7:0] q[$];
        int         depth;
        logic       ov, dv;
        logic [7:0] dr, dout;
        if (big) begin q = q16; depth = 16; ov = ovf16; dr = drop16; end
        else     begin q = q4;  depth = 4;  ov = ovf4;  dr = drop4;  end
        dout = 8'd0;
        dv   = 1'b0;
        if (flush) begin
            q.delete();
            ov = 1'b0;
            dr = 8'd0;
        end else begin
            if (rden && q.size() > 0) begin
                dout = q.pop_front();
                dv   = 1'b1;
            end
            if (ev) begin
                if (q.size() < depth) q.push_back(in_code);
                else begin
                    ov = 1'b1;
                    if (dr != 8'd255) dr = dr + 8'd1;
                end
            end
        end
        if (big) begin q16 = q; ovf16 = ov; drop16 = dr; dout16 = dout; dv16 = dv; end
        else     begin q4 = q;  ovf4 = ov;  drop4 = dr;  dout4 = dout;  dv4 = dv;  end
    endtask

    task automatic check_all();
        logic [7:0] exp_b;
        exp_b = (q4.size() != 0) ? q4[0] : 8'd0;
        check("a_dout",  32'(if_a.dataout),    32'(dout4));
        check("a_dv",    32'(if_a.dout_valid), 32'(dv4));
        check("a_count", 32'(if_a.count),      32'(q4.size()));
        check("a_empty", 32'(if_a.empty),      32'(q4.size() == 0));
        check("a_full",  32'(if_a.full),       32'(q4.size() == 4));
        check("a_ovf",   32'(if_a.overflow),   32'(ovf4));
        check("a_drop",  32'(if_a.drop_cnt),   32'(drop4));
        check("b_dout",  32'(if_b.dataout),    32'(exp_b));
        check("b_dv",    32'(if_b.dout_valid), 32'(q4.size() != 0));
        check("b_count", 32'(if_b.count),      32'(q4.size()));
        check("b_ovf",   32'(if_b.overflow),   32'(ovf4));
        check("b_drop",  32'(if_b.drop_cnt),   32'(drop4));
        check("c_dout",  32'(if_c.dataout),    32'(dout16));
        check("c_dv",    32'(if_c.dout_valid), 32'(dv16));
        check("c_count", 32'(if_c.count),      32'(q16.size()));
        check("c_empty", 32'(if_c.empty),      32'(q16.size() == 0));
        check("c_full",  32'(if_c.full),       32'(q16.size() == 16));
        check("c_ovf",   32'(if_c.overflow),   32'(ovf16));
        check("c_drop",  32'(if_c.drop_cnt),   32'(drop16));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cyc(input logic [7:0] code, input bit rd, input bit fl);
        bit ev;
        in_code = code;
        rden    = rd;
        flush   = fl;
        ev      = (code != 8'd0) && (code != prev_code);
        step_model(1'b0, ev);
        step_model(1'b1, ev);
        prev_code = code;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] code;
        rst = 1'b1; flush = 1'b0; in_code = 8'd0; rden = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();

        // Held keys give one entry each; registered reads lag rden by a cycle.
        repeat (5) cyc(8'h41, 0, 0);
        repeat (2) cyc(8'h00, 0, 0);
        repeat (3) cyc(8'h42, 0, 0);
        check("t1_count", 32'(if_c.count), 32'd2);
        cyc(8'h00, 1, 0);
        check("t1_first", 32'(if_c.dataout), 32'h41);
        cyc(8'h00, 1, 0);
        check("t1_second", 32'(if_c.dataout), 32'h42);
        cyc(8'h00, 0, 0);

        // Direct change between nonzero codes is a new event.
        cyc(8'h61, 0, 0); cyc(8'h62, 0, 0); cyc(8'h00, 0, 0);
        check("t2_count", 32'(if_a.count), 32'd2);
        repeat (3) cyc(8'h00, 1, 0);

        // Overfill the 4-deep queue, then push+pop while full.
        for (int i = 1; i <= 5; i++) begin
            cyc(8'(i), 0, 0);
            cyc(8'h00, 0, 0);
        end
        check("t3_full", 32'(if_a.full), 32'd1);
        check("t3_drop", 32'(if_a.drop_cnt), 32'd1);
        cyc(8'h09, 1, 0);
        check("t3_cnt_pp", 32'(if_a.count), 32'd4);
        check("t3_drop_pp", 32'(if_a.drop_cnt), 32'd1);
        repeat (5) cyc(8'h00, 1, 0);

        // Fall-through shows the entry with no rden.
        cyc(8'h30, 0, 0);
        check("t4_fwft", 32'(if_b.dataout), 32'h30);
        cyc(8'h00, 1, 0);
        check("t4_empty", 32'(if_b.empty), 32'd1);

        // Flush beats a simultaneous key event and pop.
        for (int i = 0; i < 5; i++) begin
            cyc(8'(8'h50 + i), 0, 0);
            cyc(8'h00, 0, 0);
        end
        cyc(8'h00, 1, 0);
        cyc(8'h77, 1, 1);
        check("t5_count", 32'(if_a.count), 32'd0);
        check("t5_ovf", 32'(if_a.overflow), 32'd0);
        repeat (2) cyc(8'h77, 0, 0);
        cyc(8'h00, 0, 0);

        // Push/pop rounds wrap the pointers.
        for (int i = 0; i < 10; i++) begin
            cyc(8'(8'h20 + i), 0, 0);
            cyc(8'h00, 1, 0);
        end

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0)      code = 8'd0;
            else if ($urandom_range(0, 2) == 0) code = prev_code;
            else                                code = 8'($urandom_range(1, 6));
            cyc(code, ($urandom_range(0, 99) < 45), ($urandom_range(0, 59) == 0));
            if (n == 700) begin
                cyc(8'h11, 0, 0); cyc(8'h12, 0, 0);
                #2 rst = 1'b1;
                #1;
                check("rst_a_count", 32'(if_a.count), 32'd0);
                check("rst_a_empty", 32'(if_a.empty), 32'd1);
                check("rst_b_dout",  32'(if_b.dataout), 32'd0);
                check("rst_b_dv",    32'(if_b.dout_valid), 32'd0);
                check("rst_c_count", 32'(if_c.count), 32'd0);
                in_code = 8'd0; rden = 1'b0; flush = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                check_all();
            end
        end

        // Continuous new events with no pops saturate the drop counter.
        repeat (2) cyc(8'h00, 0, 0);
        for (int i = 0; i < 300; i++) cyc((i % 2 == 0) ? 8'h10 : 8'h11, 0, 0);
        check("sat_a", 32'(if_a.drop_cnt), 32'd255);
        check("sat_c", 32'(if_c.drop_cnt), 32'd255);
        cyc(8'h00, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_char_fifo.md
Name: kbd_char_fifo

Overview:
Parametrised single-clock character queue between the PS/2 scan-code-to-ASCII decoder and the CPU keyboard MMIO port.
- Accepts one entry per key event from a level-held code bus.
- Stores up to DEPTH entries; every slot is usable.
- Pop handshake has a selectable output mode.
- Reports occupancy, full/empty, and a sticky overflow indication with a saturating drop counter.

Parameters:
DATA_W, 8, width of a character code; code value 0 means "no key".
DEPTH, 16, number of entries; power of two, at least 2.
FWFT, 0, output mode: 0 = registered read (data one cycle after rden); 1 = first-word-fall-through.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of queue contents and status.
in_code  in  DATA_W  code from decoder; held nonzero while key is down, 0 when idle.
rden  in  1  pop request.
dataout  out  DATA_W  popped or presented character; 0 when nothing is valid.
dout_valid  out  1  dataout carries a character.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky; a key event was dropped because the queue was full.
drop_cnt  out  8  number of dropped events; saturates at 255.

Behaviour:
- Reset (asynchronous) clears everything:
  - head, tail, count, overflow, drop_cnt, dataout and dout_valid all go to 0.
  - The arm flag goes to 1.
- Key event: a cycle with in_code != 0 and (arm == 1 or in_code != last_code).
  - last_code is the registered in_code value from the previous cycle.
  - A direct change between two nonzero codes is a new event.
  - A held code produces exactly one event.
- Arm flag:
  - Cleared on every key event, whether accepted or dropped.
  - Set in any cycle with in_code == 0.
- Push when a key event occurs and the queue is not full:
  - mem[tail] <= in_code.
  - tail wraps modulo DEPTH.
  - count increments, unless a pop happens in the same cycle.
- Push when full with no pop in the same cycle: the event is dropped.
  - overflow <= 1.
  - drop_cnt increments, saturating at 255.
  - Memory and pointers are unchanged.
- Full with a pop in the same cycle: the push is accepted, count stays DEPTH, no drop.
- FWFT=0 (registered read):
  - rden with !empty: dataout <= mem[head], dout_valid <= 1 on the next cycle, head advances, count decrements.
  - Otherwise: dataout <= 0, dout_valid <= 0.
  - rden while empty is ignored and has no side effects.
- FWFT=1 (fall-through):
  - dataout = mem[head] and dout_valid = 1 whenever !empty; otherwise dataout = 0 and dout_valid = 0. These outputs are combinational from registered state.
  - rden with dout_valid pops: head advances and count decrements.
- Push and pop in the same cycle while empty:
  - The pop is ignored, since empty is sampled before the push.
  - The push lands, and the entry becomes visible the next cycle.
- flush has priority over push and pop in the same cycle:
  - head, tail, count, overflow and drop_cnt go to 0.
  - dataout and dout_valid go to 0 in FWFT=0 mode.
  - A key event in the flush cycle is discarded, but the arm flag still updates per its rule.
- Wrap-around: head and tail are $clog2(DEPTH)-bit pointers that roll over naturally. full and empty come from count, never from a pointer comparison.
- Reset mid-operation: takes effect immediately, regardless of clk.

Decomposition:
- Shared package kbd_pkg holds:
  - KBD_DATA_W = 8.
  - KBD_NOKEY = 0.
  - Default KBD_FIFO_DEPTH = 16.
- One natural sub-module, kbd_fifo_mem: a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port addressed by head. kbd_char_fifo keeps the edge detection, pointers, count, status and output mode.

Test Plan:
1. Hold in_code=8'h41 for 5 cycles, then 0 for 2, then 8'h42 for 3 cycles. -> count=2; with FWFT=0, rden on two consecutive cycles returns 8'h41 then 8'h42, each one cycle after its rden with dout_valid=1; count=0.
2. in_code goes 8'h61 -> 8'h62 directly with no 0 between. -> two entries queued (8'h61, 8'h62).
3. DEPTH=4: push 5 distinct events separated by 0 cycles. -> full=1, count=4, overflow=1, drop_cnt=1; draining returns the first 4 codes in order. Then push and pop in the same cycle while full. -> count stays 4, drop_cnt stays 1.
4. FWFT=1: push 8'h30. -> the next cycle shows dataout=8'h30 and dout_valid=1 with no rden; after rden, dataout=0 and empty=1.
5. Queue holds 3 entries with overflow=1; assert flush together with rden and a key event. -> count=0, empty=1, overflow=0, drop_cnt=0, dout_valid=0; the key is not queued.
6. DEPTH=4: perform 10 push/pop rounds so the pointers wrap. -> data stays in order. Assert rst mid-stream asynchronously. -> all outputs 0 before the next clk edge.
